// File: rtl/sample_loader.sv
// sample_loader: collects L1+L4-word samples into a shadow buffer and presents each for PERIOD cycles; define SAMPLE_LOADER_FRAMING_CHECK_EN to compile in s_last framing checks.
module sample_loader #(
    parameter int L1        = 4,
    parameter int L4        = 2,
    parameter int DATA_W    = 16,
    parameter int PERIOD    = 16,
    parameter int N_SAMPLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [L1*DATA_W-1:0]         a1,
    output logic [L4*DATA_W-1:0]         y,
    output logic                         enable,
    output logic [$clog2(N_SAMPLES)-1:0] sample_cnt,
    output logic                         epoch_done,
    output logic                         frame_err
);
    localparam int W  = L1 + L4;
    localparam int WW = $clog2(W);
    localparam int HW = $clog2(PERIOD);
    localparam int SW = $clog2(N_SAMPLES);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_next;
    logic              load, hold_end, accept, take, last_word, shadow_full;
    logic [WW-1:0]     wcnt;
    logic [HW-1:0]     hcnt;
    logic [DATA_W-1:0] shadow [W];

    assign s_ready   = reset && !shadow_full;
    assign accept    = s_valid && s_ready;
    assign last_word = wcnt == WW'(W-1);
    assign enable    = state == HOLD;

`ifdef SAMPLE_LOADER_FRAMING_CHECK_EN
    logic resync, bad;
    assign bad  = accept && !resync && (s_last != last_word);
    assign take = accept && !resync && !bad;
    // Sticky error flag; after a missing s_last, drop words until one carries s_last
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            resync    <= 1'b0;
        end else begin
            if (bad) frame_err <= 1'b1;
            if (accept) resync <= (resync || bad) && !s_last;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign take        = accept;
    assign frame_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Swap decision from the registered shadow_full only
    always_comb begin
        hold_end   = hcnt == HW'(PERIOD-1);
        load       = shadow_full && (state == IDLE || hold_end);
        state_next = state;
        if (load) state_next = HOLD;
        else if (state == HOLD && hold_end) state_next = IDLE;
    end

    // Shadow fill, presentation copy and sample/epoch counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt        <= '0;
            hcnt        <= '0;
            shadow_full <= 1'b0;
            a1          <= '0;
            y           <= '0;
            sample_cnt  <= '0;
            epoch_done  <= 1'b0;
            for (int i = 0; i < W; i++) shadow[i] <= '0;
        end else begin
            if (accept) wcnt <= (take && !last_word) ? wcnt + 1'b1 : '0;
            if (take) shadow[wcnt] <= s_data;
            shadow_full <= (shadow_full && !load) || (take && last_word);
            hcnt        <= (load || state == IDLE) ? '0 : hcnt + 1'b1;
            epoch_done  <= load && sample_cnt == SW'(N_SAMPLES-1);
            if (load) begin
                sample_cnt <= (sample_cnt == SW'(N_SAMPLES-1)) ? '0 : sample_cnt + 1'b1;
                for (int i = 0; i < L1; i++) a1[i*DATA_W +: DATA_W] <= shadow[i];
                for (int i = 0; i < L4; i++) y[i*DATA_W +: DATA_W] <= shadow[L1+i];
            end
        end
    end
endmodule

// File: tb/tb_sample_loader.sv
// tb_sample_loader: table vectors, directed corner sequences and a queue-based reference model for sample_loader.
module tb_sample_loader;
    localparam int L1 = 4, L4 = 2, DW = 16, PERIOD = 16, NS = 8, W = L1 + L4;

    logic                clk = 0, reset = 0, s_valid = 0, s_last = 0;
    logic [DW-1:0]       s_data = 0;
    logic                s_ready, enable, epoch_done, frame_err;
    logic [L1*DW-1:0]    a1;
    logic [L4*DW-1:0]    y;
    logic [2:0]          sample_cnt;

    int checks = 0, errors = 0;

    // reference model: word queues and a remaining-hold-cycles count
    logic [DW-1:0] part[$], pend[$], pres[$];
    int  left = 0, loads = 0;
    bit  ep_m = 0, model_on = 1;

    // observations collected every cycle
    int          en_run = 0, max_run = 0, chg_at = -1, ep_pulses = 0, ep_cnt_at = -1;
    logic [63:0] prev_a1 = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        en;
        logic [63:0] ea1;
        logic [31:0] ey;
        int          cnt;
    } vec_t;
    vec_t tbl[8];

    sample_loader dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .a1(a1), .y(y), .enable(enable), .sample_cnt(sample_cnt),
        .epoch_done(epoch_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_a1();
        logic [63:0] v;
        v = '0;
        if (pres.size() == W) for (int i = 0; i < L1; i++) v[i*DW +: DW] = pres[i];
        return v;
    endfunction

    function automatic logic [63:0] m_y();
        logic [63:0] v;
        v = '0;
        if (pres.size() == W) for (int i = 0; i < L4; i++) v[i*DW +: DW] = pres[L1+i];
        return v;
    endfunction

    task automatic m_reset();
        part = {}; pend = {}; pres = {};
        left = 0; loads = 0; ep_m = 0;
    endtask

    task automatic model_edge();
        bit acc;
        acc  = s_valid && pend.size() != W;
        ep_m = 0;
        if (left > 0) left--;
        if (left == 0 && pend.size() == W) begin
            pres = pend; pend = {};
            left = PERIOD; loads++;
            ep_m = (loads % NS == 0);
        end
        if (acc) begin
            part.push_back(s_data);
            if (part.size() == W) begin pend = part; part = {}; end
        end
    endtask

    task automatic compare_all();
        chk("m.ready", s_ready, reset && pend.size() != W);
        chk("m.enable", enable, left > 0);
        chk("m.a1", a1, m_a1());
        chk("m.y", y, m_y());
        chk("m.sample_cnt", sample_cnt, loads % NS);
        chk("m.epoch_done", epoch_done, ep_m);
        chk("m.frame_err", frame_err, 0);
    endtask

    task automatic clr_obs();
        en_run = 0; max_run = 0; chg_at = -1; ep_pulses = 0; ep_cnt_at = -1; prev_a1 = a1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on && reset) model_edge();
        #1;
        if (model_on) compare_all();
        en_run = enable ? en_run + 1 : 0;
        if (en_run > max_run) max_run = en_run;
        if (enable && en_run > 1 && a1 != prev_a1) chg_at = en_run - 1;
        prev_a1 = a1;
        if (epoch_done) begin ep_pulses++; ep_cnt_at = int'(sample_cnt); end
    endtask

    task automatic idle(int n);
        s_valid = 0; s_last = 0;
        repeat (n) tick();
    endtask

    task automatic push_words(int first, int n, int pct, bit rnd);
        int k = 0, guard = 0;
        while (k < n) begin
            s_valid = ($urandom_range(99) < pct);
            s_data  = rnd ? DW'($urandom) : DW'(first + k);
            s_last  = (part.size() == W - 1);
            if (s_valid && pend.size() != W) k++;
            tick();
            if (++guard > 5000) begin
                checks++; errors++;
                $display("FAIL push_timeout accepted=%0d required=%0d", k, n);
                break;
            end
        end
        s_valid = 0; s_last = 0;
    endtask

    task automatic do_reset();
        s_valid = 0; s_last = 0; reset = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = '{1'b1, 16'(i + 1), logic'(i != 5), 1'b0, 64'h0, 32'h0, 0};
        tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b1, 64'h0004_0003_0002_0001, 32'h0006_0005, 1};
        tbl[7] = tbl[6];

        // reset held three cycles, then released
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", s_ready, 0);
        chk("rst.enable", enable, 0);
        chk("rst.a1", a1, 0);
        chk("rst.y", y, 0);
        chk("rst.cnt", sample_cnt, 0);
        chk("rst.epoch", epoch_done, 0);
        chk("rst.ferr", frame_err, 0);
        reset = 1;
        m_reset();
        tick();
        chk("rel.ready", s_ready, 1);

        // single sample from the vector table
        clr_obs();
        for (int i = 0; i < 8; i++) begin
            s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].v && tbl[i].d == 6;
            tick();
            chk($sformatf("tbl%0d.ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d.enable", i), enable, tbl[i].en);
            chk($sformatf("tbl%0d.a1", i), a1, tbl[i].ea1);
            chk($sformatf("tbl%0d.y", i), y, tbl[i].ey);
            chk($sformatf("tbl%0d.cnt", i), sample_cnt, tbl[i].cnt);
        end
        s_valid = 0; s_last = 0;
        for (int i = 0; i < 40 && enable; i++) tick();
        chk("single.en_len", max_run, 16);
        chk("single.cnt", sample_cnt, 1);

        // back-to-back samples
        do_reset();
        clr_obs();
        push_words(1, 12, 100, 0);
        chk("b2b.ready_low", s_ready, 0);
        idle(40);
        chk("b2b.en_len", max_run, 32);
        chk("b2b.swap_at", chg_at, 16);
        chk("b2b.a1", a1, 64'h000A_0009_0008_0007);
        chk("b2b.y", y, 32'h000C_000B);

        // last word lands on the hold-end edge: one enable-low cycle
        do_reset();
        push_words(1, 6, 100, 0);
        tick();
        push_words(7, 5, 100, 0);
        idle(10);
        push_words(12, 1, 100, 0);
        chk("gap.enable_low", enable, 0);
        tick();
        chk("gap.enable_high", enable, 1);
        chk("gap.a1", a1, 64'h000A_0009_0008_0007);

        // epoch wrap
        do_reset();
        clr_obs();
        push_words(1, 8 * W, 100, 0);
        idle(3 * PERIOD);
        chk("epoch.pulses", ep_pulses, 1);
        chk("epoch.cnt_at_pulse", ep_cnt_at, 0);
        chk("epoch.cnt_wrapped", sample_cnt, 0);
        push_words(100, W, 100, 0);
        idle(PERIOD + 4);
        chk("epoch.cnt_ninth", sample_cnt, 1);
        chk("epoch.pulses_after", ep_pulses, 1);

        // asynchronous reset mid-hold with a partial shadow
        do_reset();
        push_words(1, 6, 100, 0);
        tick();
        push_words(7, 3, 100, 0);
        idle(4);
        reset = 0;
        #1;
        chk("arst.a1", a1, 0);
        chk("arst.y", y, 0);
        chk("arst.enable", enable, 0);
        chk("arst.cnt", sample_cnt, 0);
        chk("arst.ready", s_ready, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        push_words(21, 6, 100, 0);
        idle(2);
        chk("arst.new_a1", a1, 64'h0018_0017_0016_0015);
        chk("arst.new_y", y, 32'h001A_0019);
        chk("arst.new_en", enable, 1);
        chk("arst.new_cnt", sample_cnt, 1);

`ifdef SAMPLE_LOADER_FRAMING_CHECK_EN
        // early s_last flags an error and the next clean sample still loads
        model_on = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = DW'(40 + i); s_last = (i == 2);
            tick();
        end
        idle(1);
        chk("frm.err", frame_err, 1);
        chk("frm.no_load", enable, 0);
        for (int i = 0; i < 6; i++) begin
            s_valid = 1; s_data = DW'(31 + i); s_last = (i == 5);
            tick();
        end
        idle(2);
        chk("frm.enable", enable, 1);
        chk("frm.a1", a1, 64'h0022_0021_0020_001F);
        chk("frm.y", y, 32'h0024_0023);
        chk("frm.sticky", frame_err, 1);
        model_on = 1;
`endif

        // randomized traffic against the model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            push_words(0, $urandom_range(1, 8), $urandom_range(30, 100), 1);
            idle($urandom_range(0, 20));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 The block SHALL have parameter L1, default 4: number of input-activation words per sample (a1 length).
REQ-002 The block SHALL have parameter L4, default 2: number of target words per sample (y length).
REQ-003 The block SHALL have parameter DATA_W, default 16: width of one signed data word (data_type).
REQ-004 The block SHALL have parameter PERIOD, default 16: cycles each sample is held for the forward network.
REQ-005 The block SHALL have parameter N_SAMPLES, default 8: samples per epoch.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 s_valid  input  1  upstream word valid.
REQ-009 s_data  input  DATA_W  upstream word, signed.
REQ-010 s_last  input  1  upstream marks final word of a sample.
REQ-011 s_ready  output  1  block accepts a word this cycle.
REQ-012 a1  output  L1 x DATA_W  presented input vector, a1[i][0].
REQ-013 y  output  L4 x DATA_W  presented target vector, y[i][0].
REQ-014 enable  output  1  high while a valid sample is presented to the forward network.
REQ-015 sample_cnt  output  clog2(N_SAMPLES)  samples presented in the current epoch.
REQ-016 epoch_done  output  1  one-cycle pulse when the N_SAMPLES-th sample of an epoch is loaded.
REQ-017 frame_err  output  1  sticky framing-error flag (see Configuration).

Function
REQ-018 A sample SHALL be W = L1+L4 words in order a1[0..L1-1] then y[0..L4-1]; a word transfers when s_valid && s_ready.
REQ-019 Accepted words SHALL fill a shadow buffer at index wcnt, wcnt 0..W-1; accepting word W-1 sets shadow_full and returns wcnt to 0.
REQ-020 s_ready SHALL equal reset && !shadow_full (registered shadow_full, no combinational path from s_valid).
REQ-021 FSM states SHALL be IDLE and HOLD; reset state IDLE.
REQ-022 IDLE: if shadow_full, at the next edge copy shadow to a1/y, clear shadow_full, set enable=1, hcnt=0, go HOLD; else remain, enable=0.
REQ-023 HOLD: a1/y SHALL be stable and enable=1; hcnt increments each cycle.
REQ-024 At hcnt==PERIOD-1: if shadow_full, reload back-to-back (enable stays 1, hcnt=0); else enable=0, go IDLE.
REQ-025 Swap decisions SHALL use registered shadow_full; a last word accepted on the same edge as hold end causes exactly one enable-low cycle before the next load.
REQ-026 Latency: last word accepted at edge E, empty presentation -> a1/y/enable updated at edge E+1.
REQ-027 Each load SHALL increment sample_cnt; the load that reaches N_SAMPLES SHALL pulse epoch_done for one cycle and wrap sample_cnt to 0.
REQ-028 Data SHALL be passed bit-exact; no arithmetic on s_data.

Reset
REQ-029 While reset=0: a1, y, enable, sample_cnt, epoch_done, frame_err, wcnt, hcnt, shadow_full SHALL be 0, state IDLE, s_ready=0.
REQ-030 Reset mid-fill or mid-hold SHALL discard the partial shadow and presented sample immediately, without waiting for clk.

Configuration
REQ-031 Macro SAMPLE_LOADER_FRAMING_CHECK_EN SHALL compile in s_last checking.
REQ-032 With the macro: s_last on index != W-1, or absent on W-1, SHALL set frame_err (sticky until reset); the offending partial sample SHALL be discarded and wcnt resynchronised to 0 after the next word carrying s_last.
REQ-033 Without the macro: s_last SHALL be ignored, frame_err tied 0, framing by wcnt only.

Verification
REQ-034 Reset: hold reset=0 3 cycles -> all outputs 0, s_ready=0; release -> s_ready=1 next cycle.
REQ-035 Single sample: words 1..6 continuous -> edge after 6th accept a1={1,2,3,4}, y={5,6}, enable=1 exactly 16 cycles then 0, sample_cnt=1.
REQ-036 Back-to-back: words 1..12 continuous -> s_ready low after word 12, enable high 32 consecutive cycles, a1 changes {1,2,3,4}->{7,8,9,10} at cycle 16.
REQ-037 Epoch: 8 samples -> epoch_done single pulse on 8th load, sample_cnt wraps to 0; 9th load gives sample_cnt=1.
REQ-038 Reset mid-hold at hcnt=7 with 3 words in shadow -> all cleared; following fresh 6-word sample presented correctly.
REQ-039 Framing (macro on): s_last on word 3 -> frame_err=1, words discarded, next correct 6-word sample loads with enable=1.
